aes_inv_round_ctrl: RTL
=======================

Name: aes_inv_round_ctrl

Overview:
Iterative AES-128 inverse-cipher controller. It sequences one shared inverse-round datapath over 10 rounds: InvShiftRows, then the 16-lane inv_sub_bytes array, then AddRoundKey, then InvMixColumns. It accepts one ciphertext block through a valid/ready handshake and fetches round keys from an external precomputed key store by index. It returns the plaintext through a valid/ready handshake and sits between the AXI-side block FIFO and the output FIFO.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported, and elaboration fails otherwise.
KIDX_W, 4, width of the round-key index.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  ciphertext block available.
in_ready  output  1  controller can accept a block.
in_data  input  [0:127]  ciphertext, big-endian bit order; byte 0 = in_data[0:7].
rk_idx  output  [KIDX_W-1:0]  round-key index requested this cycle.
rk_data  input  [0:127]  round key for rk_idx, combinational (same-cycle) from the key store.
out_valid  output  1  plaintext valid.
out_ready  input  1  consumer accepts the plaintext.
out_data  output  [0:127]  plaintext, same bit order as in_data.
busy  output  1  a block is in flight or waiting in DONE.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - FSM = IDLE, round counter = 0, state register = 0.
  - out_valid = 0, in_ready = 1, busy = 0, rk_idx = 10, out_data = 0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1 and rk_idx = 10.
  - On in_valid & in_ready: state <= in_data ^ rk_data (initial AddRoundKey with key 10), rnd <= 9, go to ROUND.
- ROUND (rnd counts 9 down to 1, then 0):
  - rk_idx = rnd.
  - Each cycle: state <= round_fn(state, rk_data, last = (rnd == 0)).
  - round_fn = InvShiftRows -> InvSubBytes -> XOR key -> InvMixColumns. InvMixColumns is skipped when last = 1.
  - When rnd == 0, go to DONE; otherwise rnd <= rnd - 1.
- DONE:
  - out_valid = 1 and out_data = state.
  - Both are held stable until out_ready is sampled high.
  - On out_valid & out_ready: go to IDLE, and out_valid drops the next cycle.
- Latency: the accept edge is cycle 0. The 10 ROUND cycles are cycles 1..10, and out_valid is high from cycle 11. Throughput is 1 block per 12 cycles when out_ready is tied high.
- in_ready is 0 in ROUND and DONE. in_valid seen in those states is ignored; the source must hold its block.
- busy = (FSM != IDLE).
- out_ready while not in DONE is ignored.
- rk_idx is a pure function of FSM and rnd, with no combinational path from any input.
- Reset asserted mid-operation aborts immediately: all registers take their reset values and the partial block is discarded.
- Back-to-back operation: the IDLE cycle after a DONE handshake is mandatory. A new block can be accepted in that IDLE cycle.

Optional Feature:
- Macro: AES_INV_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort sampled high in ROUND or DONE forces IDLE on the next edge: out_valid = 0, state cleared to 0, and the block is never presented.
  - abort in IDLE has no effect.
  - abort coinciding with an out_valid & out_ready handshake: the handshake completes and the block counts as delivered.
- When undefined: the port does not exist and behaviour is exactly as above.

Decomposition:
- Shared package aes_inv_pkg holds:
  - constant AES_NR = 10;
  - typedef aes_block_t [0:127];
  - FSM state enum {S_IDLE, S_ROUND, S_DONE};
  - the reset value of rk_idx.
- One sub-module, aes_inv_round: a combinational round function with inputs state, key and last, and output next. It instantiates inv_shift_rows, inv_sub_bytes and inv_mix_columns, plus the XOR. The controller holds only the FSM, the counter and the state register.

Test Plan:
- FIPS-197 C.1: key schedule from 000102030405060708090a0b0c0d0e0f, in_data = 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready = 1 -> out_data = 00112233445566778899aabbccddeeff with out_valid high exactly at cycle 11 after accept.
- rk_idx sequence check during the above: 10 at accept, then 9,8,...,1,0 in cycles 1..10, and 10 again after returning to IDLE.
- Backpressure: out_ready held 0 for 20 cycles after DONE -> out_valid and out_data stay stable, in_ready = 0, and a second in_valid is not accepted. Releasing out_ready -> the handshake completes, and the second block is accepted in the following IDLE cycle.
- Back-to-back: 3 C.1 blocks with in_valid and out_ready always high -> three identical correct outputs, accept edges 12 cycles apart.
- Reset mid-round: deassert rst_n at cycle 5 -> asynchronously out_valid = 0, in_ready = 1, busy = 0. After release, a fresh C.1 block decrypts correctly.
- With AES_INV_ABORT_EN: abort pulsed at cycle 6 -> IDLE at cycle 7, no out_valid. The next block decrypts correctly.

Source files
------------

// File: rtl/aes_inv_pkg.sv
// rtl/aes_inv_pkg.sv - shared types, constants and GF(2^8) helpers for the AES inverse-round controller
package aes_inv_pkg;

  localparam int AES_NR         = 10;
  localparam int AES_RK_IDX_RST = AES_NR;

  typedef logic [0:127] aes_block_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } aes_fsm_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and conveniently maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Undo the S-box affine map, then invert in the field
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns
module aes_inv_round
  import aes_inv_pkg::*;
(
  input  aes_block_t state,
  input  aes_block_t key,
  input  logic       last,
  output aes_block_t next
);

  aes_block_t shifted;
  aes_block_t subbed;
  aes_block_t keyed;
  aes_block_t mixed;

  inv_shift_rows u_shift_rows (
    .din  (state),
    .dout (shifted)
  );

  inv_sub_bytes u_sub_bytes (
    .din  (shifted),
    .dout (subbed)
  );

  assign keyed = subbed ^ key;

  inv_mix_columns u_mix_columns (
    .din  (keyed),
    .dout (mixed)
  );

  // The final round has no InvMixColumns
  assign next = last ? keyed : mixed;

endmodule

// File: rtl/inv_mix_columns.sv
// rtl/inv_mix_columns.sv - AES InvMixColumns over the four state columns
module inv_mix_columns
  import aes_inv_pkg::*;
(
  input  aes_block_t din,
  output aes_block_t dout
);

  // Each column is multiplied by the circulant {0e,0b,0d,09}
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = din[32*c      +: 8];
    assign a1 = din[32*c + 8  +: 8];
    assign a2 = din[32*c + 16 +: 8];
    assign a3 = din[32*c + 24 +: 8];
    assign dout[32*c      +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign dout[32*c + 8  +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign dout[32*c + 16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign dout[32*c + 24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end

endmodule

// File: rtl/inv_shift_rows.sv
// rtl/inv_shift_rows.sv - AES InvShiftRows, row r rotated right by r columns
module inv_shift_rows
  import aes_inv_pkg::*;
(
  input  aes_block_t din,
  output aes_block_t dout
);

  // Byte r+4c of the output comes from column (c-r) mod 4 of the same row
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign dout[8*(r+4*c) +: 8] = din[8*(r+4*((c-r+4)%4)) +: 8];
    end
  end

endmodule

// File: rtl/inv_sub_bytes.sv
// rtl/inv_sub_bytes.sv - 16-lane AES inverse S-box array
module inv_sub_bytes
  import aes_inv_pkg::*;
(
  input  aes_block_t din,
  output aes_block_t dout
);

  // One independent inverse S-box per byte lane
  for (genvar lane = 0; lane < 16; lane++) begin : g_lane
    assign dout[8*lane +: 8] = inv_sbox(din[8*lane +: 8]);
  end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// rtl/aes_inv_round_ctrl.sv - iterative AES-128 inverse-cipher controller; optional abort input under AES_INV_ABORT_EN
module aes_inv_round_ctrl
  import aes_inv_pkg::*;
#(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:127]      in_data,
  output logic [KIDX_W-1:0] rk_idx,
  input  logic [0:127]      rk_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:127]      out_data,
  output logic              busy
`ifdef AES_INV_ABORT_EN
  ,
  input  logic              abort
`endif
);

  if (NR != AES_NR) begin : g_nr_check
    $fatal(1, "aes_inv_round_ctrl: only NR = 10 (AES-128) is supported");
  end

  localparam logic [KIDX_W-1:0] RK_RST   = KIDX_W'(AES_RK_IDX_RST);
  localparam logic [KIDX_W-1:0] LAST_RND = KIDX_W'(NR - 1);

  aes_fsm_t          fsm_q;
  logic [KIDX_W-1:0] rnd_q;
  aes_block_t        state_q;
  aes_block_t        round_next;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [KIDX_W-1:0] rk_idx_q;
  logic              abort_hit;

  aes_inv_round u_round (
    .state (state_q),
    .key   (rk_data),
    .last  (rnd_q == '0),
    .next  (round_next)
  );

`ifdef AES_INV_ABORT_EN
  // A handshake in the same cycle as abort wins: the block counts as delivered
  assign abort_hit = abort && (fsm_q != S_IDLE) && !((fsm_q == S_DONE) && out_ready);
`else
  assign abort_hit = 1'b0;
`endif

  // FSM, round counter, state register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= S_IDLE;
      rnd_q       <= '0;
      state_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rk_idx_q    <= RK_RST;
    end else if (abort_hit) begin
      fsm_q       <= S_IDLE;
      rnd_q       <= '0;
      state_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rk_idx_q    <= RK_RST;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (in_valid) begin
            state_q    <= in_data ^ rk_data;
            rnd_q      <= LAST_RND;
            rk_idx_q   <= LAST_RND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            fsm_q      <= S_ROUND;
          end
        end
        S_ROUND: begin
          state_q <= round_next;
          if (rnd_q == '0) begin
            fsm_q       <= S_DONE;
            out_valid_q <= 1'b1;
            rk_idx_q    <= RK_RST;
          end else begin
            rnd_q    <= rnd_q - 1'b1;
            rk_idx_q <= rnd_q - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            fsm_q       <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          fsm_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign rk_idx    = rk_idx_q;
  assign out_data  = state_q;

endmodule
